// File: rtl/pokey_key_matrix.sv
// Keyboard matrix responder for the POKEY scanner: answers K[5:0] scans on KR[2:1] from a
// host-loaded key bitmap and modifier flags, holding each event for a number of scan passes.
module pokey_key_matrix #(
  parameter int unsigned MIN_SCANS = 2,
  parameter int unsigned TIMEOUT   = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] K,
  output logic [2:1] KR,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic [1:0] ev_type,
  input  logic [5:0] ev_code,
  input  logic       ev_make,
  input  logic       clr_all,
  output logic       key_any,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [3:0]  MinScans = 4'(MIN_SCANS);
  localparam logic [15:0] Timeout  = 16'(TIMEOUT);

  state_e      state;
  logic [63:0] bitmap;
  logic        shift_f;
  logic        ctrl_f;
  logic        brk_f;
  logic [5:0]  kq;
  logic [3:0]  pass_cnt;
  logic [15:0] to_cnt;

  logic        pass;
  logic        accept;
  logic        kr2_hit;
  logic        hold_done;
  logic [3:0]  pass_nxt;
  logic [15:0] to_nxt;

  // A pass is the scan address wrapping back to 3F after visiting other rows.
  assign pass      = (kq != 6'h3F) && (K == 6'h3F);
  assign ev_ready  = (state == StIdle) & ~reset & ~clr_all;
  assign accept    = ev_valid & ev_ready;
  assign busy      = (state == StHold);
  assign key_any   = |bitmap;
  assign pass_nxt  = pass ? pass_cnt + 4'd1 : pass_cnt;
  assign to_nxt    = (to_cnt == 16'hFFFF) ? to_cnt : to_cnt + 16'd1;
  assign hold_done = (pass_nxt == MinScans) || ((Timeout != 16'd0) && (to_nxt == Timeout));
  assign kr2_hit   = ((K == 6'h3F) & ctrl_f) | ((K == 6'h2F) & shift_f) | ((K == 6'h0F) & brk_f);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      bitmap   <= '0;
      shift_f  <= 1'b0;
      ctrl_f   <= 1'b0;
      brk_f    <= 1'b0;
      kq       <= 6'h3F;
      pass_cnt <= '0;
      to_cnt   <= '0;
      KR       <= 2'b11;
    end else begin
      kq    <= K;
      KR[1] <= ~bitmap[K];
      KR[2] <= ~kr2_hit;
      if (clr_all) begin
        state    <= StIdle;
        bitmap   <= '0;
        shift_f  <= 1'b0;
        ctrl_f   <= 1'b0;
        brk_f    <= 1'b0;
        pass_cnt <= '0;
        to_cnt   <= '0;
      end else if (accept) begin
        unique case (ev_type)
          2'd0: bitmap[ev_code] <= ev_make;
          2'd1: shift_f <= ev_make;
          2'd2: ctrl_f <= ev_make;
          2'd3: brk_f <= ev_make;
        endcase
        state    <= StHold;
        pass_cnt <= '0;
        to_cnt   <= '0;
      end else if (state == StHold) begin
        pass_cnt <= pass_nxt;
        to_cnt   <= to_nxt;
        if (hold_done) begin
          state <= StIdle;
        end
      end
    end
  end

endmodule
